// File: rtl/xsleena_palette_out.sv
// Palette RAM + 2-stage colour lookup feeding the RGB LUTs; CPU byte writes wait for a free RAM cycle.
// Optional CPU readback port enabled by defining XSLEENA_PAL_READBACK_EN.
module xsleena_palette_out #(
  parameter int          IDX_W     = 9,
  parameter logic [11:0] BLANK_COL = 12'h000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pix_ce,
  input  logic [IDX_W-1:0] i_pix_idx,
  input  logic             i_hblank,
  input  logic             i_vblank,
  input  logic [IDX_W:0]   i_cpu_addr,
  input  logic [7:0]       i_cpu_din,
  input  logic             i_cpu_we,
`ifdef XSLEENA_PAL_READBACK_EN
  input  logic             i_cpu_re,
  output logic [7:0]       o_cpu_dout,
  output logic             o_cpu_rvalid,
`endif
  output logic             o_cpu_busy,
  output logic [3:0]       o_R_4BIT,
  output logic [3:0]       o_G_4BIT,
  output logic [3:0]       o_B_4BIT,
  output logic             o_hblank_out,
  output logic             o_vblank_out
);

  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  // Entry layout {B,G,R}; not reset.
  logic [11:0]      r_ram [2**IDX_W];

  logic [IDX_W-1:0] r_s1_idx;
  logic             r_s1_hb, r_s1_vb;
  logic [11:0]      r_col;
  logic             r_hb_out, r_vb_out;
  state_t           r_state;
  logic             r_busy;
  logic [IDX_W:0]   r_paddr;
  logic [7:0]       r_pdata;

  logic             w_s1_blank, w_ram_free, w_commit, w_wr;
  logic [IDX_W-1:0] w_ram_addr;
  logic [11:0]      w_ram_q;

  assign w_s1_blank = r_s1_hb | r_s1_vb;
  // A blanked S1 means the next tick skips the lookup, so the port is ours.
  assign w_ram_free = ~i_pix_ce | w_s1_blank;
  assign w_commit   = (r_state == ST_PEND) & w_ram_free & ~i_reset;
  assign w_ram_addr = w_commit ? r_paddr[IDX_W:1] : r_s1_idx;
  assign w_ram_q    = r_ram[w_ram_addr];

`ifdef XSLEENA_PAL_READBACK_EN
  logic       r_prd;
  logic [7:0] r_dout;
  logic       r_rvalid;
  assign w_wr         = w_commit & ~r_prd;
  assign o_cpu_dout   = r_dout;
  assign o_cpu_rvalid = r_rvalid;
`else
  assign w_wr = w_commit;
`endif

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      if (r_paddr[0]) r_ram[w_ram_addr][11:8] <= r_pdata[3:0];
      else            r_ram[w_ram_addr][7:0]  <= r_pdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_idx <= '0;
      r_s1_hb  <= 1'b1;
      r_s1_vb  <= 1'b1;
      r_col    <= '0;
      r_hb_out <= 1'b1;
      r_vb_out <= 1'b1;
    end else if (i_pix_ce) begin
      r_s1_idx <= i_pix_idx;
      r_s1_hb  <= i_hblank;
      r_s1_vb  <= i_vblank;
      r_col    <= w_s1_blank ? BLANK_COL : w_ram_q;
      r_hb_out <= r_s1_hb;
      r_vb_out <= r_s1_vb;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_paddr  <= '0;
      r_pdata  <= '0;
`ifdef XSLEENA_PAL_READBACK_EN
      r_prd    <= 1'b0;
      r_dout   <= '0;
      r_rvalid <= 1'b0;
`endif
    end else begin
`ifdef XSLEENA_PAL_READBACK_EN
      r_rvalid <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (i_cpu_we) begin
            r_paddr <= i_cpu_addr;
            r_pdata <= i_cpu_din;
            r_state <= ST_PEND;
            r_busy  <= 1'b1;
`ifdef XSLEENA_PAL_READBACK_EN
            r_prd   <= 1'b0;
          end else if (i_cpu_re) begin
            r_paddr <= i_cpu_addr;
            r_prd   <= 1'b1;
            r_state <= ST_PEND;
            r_busy  <= 1'b1;
`endif
          end
        end
        ST_PEND: begin
          if (w_ram_free) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
`ifdef XSLEENA_PAL_READBACK_EN
            if (r_prd) begin
              r_rvalid <= 1'b1;
              r_dout   <= r_paddr[0] ? {4'h0, w_ram_q[11:8]} : w_ram_q[7:0];
            end
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cpu_busy   = r_busy;
  assign o_R_4BIT     = r_col[3:0];
  assign o_G_4BIT     = r_col[7:4];
  assign o_B_4BIT     = r_col[11:8];
  assign o_hblank_out = r_hb_out;
  assign o_vblank_out = r_vb_out;

endmodule

// File: tb/tb_xsleena_palette_out.sv
// Randomised + directed bench for xsleena_palette_out against a transaction-level palette model.
module tb_xsleena_palette_out;
  logic       clk = 1'b0;
  logic       reset, pix_ce, hblank, vblank, cpu_we, cpu_busy;
  logic [8:0] pix_idx;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_din;
  logic [3:0] r4, g4, b4;
  logic       hb_out, vb_out;

  always #5 clk = ~clk;

  xsleena_palette_out dut (
    .i_clk(clk), .i_reset(reset), .i_pix_ce(pix_ce), .i_pix_idx(pix_idx),
    .i_hblank(hblank), .i_vblank(vblank), .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din),
    .i_cpu_we(cpu_we), .o_cpu_busy(cpu_busy), .o_R_4BIT(r4), .o_G_4BIT(g4),
    .o_B_4BIT(b4), .o_hblank_out(hb_out), .o_vblank_out(vb_out)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: palette array, a 2-entry pixel pipe, and one pending-write slot.
  logic [11:0] m_ram [0:511];
  logic [8:0]  m_s1_idx;
  logic        m_s1_hb, m_s1_vb;
  logic [11:0] m_col;
  logic        m_hbo, m_vbo;
  logic        m_pend;
  logic [9:0]  m_pa;
  logic [7:0]  m_pd;

  always @(posedge clk) begin
    if (reset) begin
      m_s1_hb <= 1'b1; m_s1_vb <= 1'b1; m_s1_idx <= '0;
      m_col <= '0; m_hbo <= 1'b1; m_vbo <= 1'b1;
      m_pend <= 1'b0;
    end else begin
      if (m_pend && (!pix_ce || m_s1_hb || m_s1_vb)) begin
        if (m_pa[0]) m_ram[m_pa[9:1]][11:8] <= m_pd[3:0];
        else         m_ram[m_pa[9:1]][7:0]  <= m_pd;
        m_pend <= 1'b0;
      end else if (!m_pend && cpu_we) begin
        m_pend <= 1'b1; m_pa <= cpu_addr; m_pd <= cpu_din;
      end
      if (pix_ce) begin
        m_col <= (m_s1_hb || m_s1_vb) ? 12'h000 : m_ram[m_s1_idx];
        m_hbo <= m_s1_hb; m_vbo <= m_s1_vb;
        m_s1_idx <= pix_idx; m_s1_hb <= hblank; m_s1_vb <= vblank;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk("R", {28'd0, r4}, {28'd0, m_col[3:0]});
    chk("G", {28'd0, g4}, {28'd0, m_col[7:4]});
    chk("B", {28'd0, b4}, {28'd0, m_col[11:8]});
    chk("hblank_out", {31'd0, hb_out}, {31'd0, m_hbo});
    chk("vblank_out", {31'd0, vb_out}, {31'd0, m_vbo});
    chk("cpu_busy", {31'd0, cpu_busy}, {31'd0, m_pend});
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
    step();
    cpu_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pix_ce = 1'b0; pix_idx = '0; hblank = 1'b1; vblank = 1'b0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    step(); step();
    chk("rst_R", {28'd0, r4}, 32'd0);
    chk("rst_hb", {31'd0, hb_out}, 32'd1);
    chk("rst_busy", {31'd0, cpu_busy}, 32'd0);
    reset = 1'b0;

    // Fill the whole palette so every later lookup is defined.
    for (int a = 0; a < 1024; a++) begin
      cpu_write(a[9:0], 8'($urandom));
      step();
    end

    // Byte-lane writes to entry 2.
    cpu_write(10'h004, 8'hA5); step();
    cpu_write(10'h005, 8'h3C); step();

    // Reset, then pix_ce toggling with blanking off.
    reset = 1'b1; step(); reset = 1'b0;
    hblank = 1'b0; vblank = 1'b0; pix_idx = 9'd2;
    pix_ce = 1'b1; step(); pix_ce = 1'b0; step();
    chk("first_tick_R", {28'd0, r4}, 32'd0);
    chk("first_tick_hb", {31'd0, hb_out}, 32'd1);
    pix_ce = 1'b1; step(); pix_ce = 1'b0; step();
    chk("lut_R", {28'd0, r4}, 32'h5);
    chk("lut_G", {28'd0, g4}, 32'hA);
    chk("lut_B", {28'd0, b4}, 32'hC);
    chk("lut_hb", {31'd0, hb_out}, 32'd0);

    // Write starved by continuous unblanked reads, second strobe ignored.
    pix_ce = 1'b1; pix_idx = 9'd8;
    cpu_write(10'h010, 8'h77);
    for (int i = 0; i < 6; i++) step();
    chk("starved_busy", {31'd0, cpu_busy}, 32'd1);
    cpu_write(10'h010, 8'h11);
    step();
    hblank = 1'b1; step(); step();
    chk("commit_busy", {31'd0, cpu_busy}, 32'd0);
    hblank = 1'b0; step(); step(); step();
    chk("first_wins_R", {28'd0, r4}, 32'h7);
    chk("first_wins_G", {28'd0, g4}, 32'h7);

    // Blanking forces BLANK_COL aligned with hblank_out.
    hblank = 1'b1; pix_idx = 9'd2; step(); step();
    chk("blank_R", {28'd0, r4}, 32'd0);
    chk("blank_B", {28'd0, b4}, 32'd0);
    chk("blank_hb", {31'd0, hb_out}, 32'd1);

    // Reset during PEND drops the write.
    hblank = 1'b0; step(); step();
    cpu_write(10'h005, 8'h0F); step(); step();
    chk("pend_busy", {31'd0, cpu_busy}, 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_pend_busy", {31'd0, cpu_busy}, 32'd0);
    step(); step();
    chk("dropped_B", {28'd0, b4}, 32'hC);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 499) == 0);
      pix_ce   = 1'($urandom);
      pix_idx  = 9'($urandom);
      hblank   = ($urandom_range(0, 7) == 0);
      vblank   = ($urandom_range(0, 15) == 0);
      cpu_we   = ($urandom_range(0, 3) == 0);
      cpu_addr = 10'($urandom);
      cpu_din  = 8'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
